// File: rtl/cbus_pkg.sv
// Shared CBus types and constants: request/response structs, burst and size
// encodings, and the arbiter state enum.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  wstrobe;
    logic [63:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] rdata;
  } cbus_resp_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Merges the instruction and data CBus masters onto one crossbar port.
// One transaction per grant; grant is held until the last response beat.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter logic FAIR        = 1'b1,
  parameter logic INIT_LAST_I = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  arb_state_t state;
  arb_state_t state_n;
  logic       last_grant;
  logic       last_grant_n;

  // Grant choice while idle; ties go to D unless round-robin says I is due.
  function automatic arb_state_t pick(input logic ivalid, input logic dvalid,
                                      input logic last_i);
    arb_state_t g;
    g = ARB_IDLE;
    if (ivalid && dvalid) begin
      g = (FAIR && !last_i) ? ARB_BUSY_I : ARB_BUSY_D;
    end else if (ivalid) begin
      g = ARB_BUSY_I;
    end else if (dvalid) begin
      g = ARB_BUSY_D;
    end
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= INIT_LAST_I;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end

  // Outputs depend only on state and the requests/response passed through,
  // so there is no path from oresp back into oreq.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    oreq         = '0;
    iresp        = '0;
    dresp        = '0;
    case (state)
      ARB_IDLE: begin
        state_n = pick(ireq.valid, dreq.valid, last_grant);
        if (state_n != ARB_IDLE) begin
          last_grant_n = (state_n == ARB_BUSY_I);
        end
      end
      ARB_BUSY_I: begin
        oreq  = ireq;
        iresp = oresp;
        if ((oresp.ready && oresp.last) || !ireq.valid) begin
          state_n = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        oreq  = dreq;
        dresp = oresp;
        if ((oresp.ready && oresp.last) || !dreq.valid) begin
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a fair and a fixed-priority instance share inputs and
// are compared every cycle against a transaction-level ownership model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_req_t  ireq, dreq, oreq_f, oreq_x;
  cbus_resp_t iresp_f, dresp_f, iresp_x, dresp_x, oresp;

  cbus_arbiter #(.FAIR(1'b1), .INIT_LAST_I(1'b1)) u_fair (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_f),
    .dreq(dreq), .dresp(dresp_f), .oreq(oreq_f), .oresp(oresp)
  );

  cbus_arbiter #(.FAIR(1'b0), .INIT_LAST_I(1'b1)) u_fixed (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_x),
    .dreq(dreq), .dresp(dresp_x), .oreq(oreq_x), .oresp(oresp)
  );

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // Reference model: who owns the crossbar port in each instance (0 fair, 1 fixed)
  int owner[2];
  bit last_i[2];

  task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      cbus_req_t  eo;
      cbus_resp_t ei, ed;
      string      nm;
      eo = '0;
      ei = '0;
      ed = '0;
      if (owner[k] == OWN_I) begin
        eo = ireq;
        ei = oresp;
      end else if (owner[k] == OWN_D) begin
        eo = dreq;
        ed = oresp;
      end
      nm = (k == 0) ? "fair" : "fixed";
      if (k == 0) begin
        check({nm, ".oreq"},  150'(oreq_f),  150'(eo));
        check({nm, ".iresp"}, 150'(iresp_f), 150'(ei));
        check({nm, ".dresp"}, 150'(dresp_f), 150'(ed));
      end else begin
        check({nm, ".oreq"},  150'(oreq_x),  150'(eo));
        check({nm, ".iresp"}, 150'(iresp_x), 150'(ei));
        check({nm, ".dresp"}, 150'(dresp_x), 150'(ed));
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        owner[k]  = OWN_NONE;
        last_i[k] = 1'b1;
      end else if (owner[k] == OWN_NONE) begin
        if (ireq.valid && dreq.valid) begin
          if (k == 0) owner[k] = last_i[k] ? OWN_D : OWN_I;
          else        owner[k] = OWN_D;
        end else if (ireq.valid) begin
          owner[k] = OWN_I;
        end else if (dreq.valid) begin
          owner[k] = OWN_D;
        end
        if (owner[k] != OWN_NONE) last_i[k] = (owner[k] == OWN_I);
      end else if (oresp.ready && oresp.last) begin
        owner[k] = OWN_NONE;
      end else if (owner[k] == OWN_I && !ireq.valid) begin
        owner[k] = OWN_NONE;
      end else if (owner[k] == OWN_D && !dreq.valid) begin
        owner[k] = OWN_NONE;
      end
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, return shortly after it so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Driver tasks
  function automatic cbus_req_t make_req(input logic [63:0] addr, input logic [7:0] len,
                                         input logic [7:0] wstrobe, input logic [63:0] wdata);
    cbus_req_t r;
    r.valid   = 1'b1;
    r.addr    = addr;
    r.size    = MSIZE8;
    r.len     = len;
    r.burst   = AXI_BURST_INCR;
    r.wstrobe = wstrobe;
    r.wdata   = wdata;
    return r;
  endfunction

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r.valid   = 1'b1;
    r.addr    = {$urandom(), $urandom()};
    r.size    = 3'($urandom_range(0, 3));
    r.len     = 8'($urandom_range(0, 7));
    r.burst   = 2'($urandom_range(0, 2));
    r.wstrobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom());
    r.wdata   = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic set_resp(input logic ready, input logic last);
    oresp.ready = ready;
    oresp.last  = last;
    oresp.rdata = {$urandom(), $urandom()};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    for (int k = 0; k < 2; k++) begin
      owner[k]  = OWN_NONE;
      last_i[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    do_reset();
    check("reset.oreq_valid", 150'(oreq_f.valid), 150'(0));

    // I read alone, len=3
    ireq = make_req(64'h8000_0000, 8'd3, 8'h00, 64'h0);
    tick();
    check("iread.oreq", 150'(oreq_f), 150'(ireq));
    for (int b = 0; b < 4; b++) begin
      set_resp(1'b1, b == 3);
      tick();
    end
    ireq  = '0;
    oresp = '0;
    check("iread.idle", 150'(oreq_f), 150'(0));
    tick();

    // Tie right after reset: D first, one idle cycle, then I
    do_reset();
    ireq = make_req(64'h1000, 8'd0, 8'h00, 64'h0);
    dreq = make_req(64'h2000, 8'd0, 8'h00, 64'h0);
    tick();
    check("tie.first_d", 150'(oreq_f.addr), 150'(64'h2000));
    set_resp(1'b1, 1'b1);
    tick();
    dreq  = '0;
    oresp = '0;
    check("tie.gap", 150'(oreq_f.valid), 150'(0));
    tick();
    check("tie.then_i", 150'(oreq_f.addr), 150'(64'h1000));
    set_resp(1'b1, 1'b1);
    tick();
    ireq  = '0;
    oresp = '0;
    tick();

    // Fixed priority: D served three times while I waits
    do_reset();
    ireq = make_req(64'h3000, 8'd0, 8'h00, 64'h0);
    for (int n = 0; n < 3; n++) exp_q.push_back(64'h4000 + 64'(n * 8));
    exp_q.push_back(64'h3000);
    for (int n = 0; n < 3; n++) begin
      dreq = make_req(64'h4000 + 64'(n * 8), 8'd0, 8'h00, 64'h0);
      set_resp(1'b1, 1'b1);
      for (int t = 0; t < 2; t++) begin
        tick();
        if (oreq_x.valid && exp_q.size() > 0) check("starve.order", 150'(oreq_x.addr), 150'(exp_q.pop_front()));
      end
    end
    dreq = '0;
    tick();
    if (oreq_x.valid && exp_q.size() > 0) check("starve.order", 150'(oreq_x.addr), 150'(exp_q.pop_front()));
    check("starve.all_seen", 150'(exp_q.size()), 150'(0));
    exp_q.delete();
    tick();
    ireq  = '0;
    oresp = '0;
    tick();

    // D write while I waits
    do_reset();
    ireq = make_req(64'h5000, 8'd1, 8'h00, 64'h0);
    dreq = make_req(64'h6000, 8'd0, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("dwrite.wstrobe", 150'(oreq_f.wstrobe), 150'(8'hFF));
    check("dwrite.wdata", 150'(oreq_x.wdata), 150'(64'hDEAD_BEEF_0123_4567));
    set_resp(1'b1, 1'b1);
    check("dwrite.iresp_ready", 150'(iresp_f.ready), 150'(0));
    tick();
    dreq  = '0;
    oresp = '0;
    tick();
    tick();
    ireq  = '0;
    tick();

    // Reset in the middle of an 8-beat I burst
    do_reset();
    ireq = make_req(64'h7000, 8'd7, 8'h00, 64'h0);
    tick();
    set_resp(1'b1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.oreq_valid", 150'(oreq_f.valid), 150'(0));
    check("rstmid.iresp", 150'(iresp_f), 150'(0));
    tick();
    check("rstmid.regrant", 150'(oreq_f), 150'(ireq));
    set_resp(1'b1, 1'b1);
    tick();
    ireq  = '0;
    oresp = '0;
    tick();

    // Abort: granted D drops valid after beat 1, pending I follows
    do_reset();
    ireq = make_req(64'h8000, 8'd0, 8'h00, 64'h0);
    dreq = make_req(64'h9000, 8'd3, 8'h00, 64'h0);
    tick();
    set_resp(1'b1, 1'b0);
    tick();
    dreq  = '0;
    oresp = '0;
    tick();
    check("abort.idle", 150'(oreq_x.valid), 150'(0));
    tick();
    check("abort.i_granted", 150'(oreq_x), 150'(ireq));
    set_resp(1'b1, 1'b1);
    tick();
    ireq  = '0;
    oresp = '0;
    tick();

    // Random traffic including drops, ties and occasional resets
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (ireq.valid) begin
        if ($urandom_range(0, 19) == 0) ireq.valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        ireq = rand_req();
      end
      if (dreq.valid) begin
        if ($urandom_range(0, 19) == 0) dreq.valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        dreq = rand_req();
      end
      set_resp($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
